// File: rtl/ad9364_ensm_ctrl_pkg.sv
// Shared encodings for the AD9364 ENSM sequencer: host mode codes,
// sequencer state codes and a small sizing helper for the timer.
package ad9364_ensm_ctrl_pkg;

    localparam logic [1:0] MODE_ALERT = 2'b00;
    localparam logic [1:0] MODE_RX    = 2'b01;
    localparam logic [1:0] MODE_TX    = 2'b10;
    localparam logic [1:0] MODE_FDD   = 2'b11;

    localparam logic [2:0] ST_ALERT  = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_RAMP   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DROP   = 3'd5;

    function automatic int max3(input int a,
                                input int b,
                                input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ad9364_ensm_ctrl_timer.sv
// ENSM phase timer: loadable down-counter that stops at zero.
// Ports: load/load_val restart the count, done is high while count==0.
module ad9364_ensm_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/ad9364_ensm_ctrl.sv
// AD9364 ENSM pin sequencer (level mode) with rx/tx datapath gating.
// Ports: cmd_valid/cmd_mode/cmd_ready host request, xcvr_enable/
// xcvr_txnrx pins, rx_enable/tx_enable to dev_if, cur_mode, busy.
module ad9364_ensm_ctrl
    import ad9364_ensm_ctrl_pkg::*;
#(
    parameter int TXNRX_SETUP_CYCLES = 4,
    parameter int SETTLE_CYCLES      = 200,
    parameter int FLUSH_CYCLES       = 16
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    output logic       xcvr_enable,
    output logic       xcvr_txnrx,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic [1:0] cur_mode,
    output logic       busy
);

    localparam int MAXN = max3(TXNRX_SETUP_CYCLES,
                               SETTLE_CYCLES,
                               FLUSH_CYCLES);
    localparam int CW = $clog2(MAXN + 1);

    localparam logic [CW-1:0] LD_SETUP  =
        CW'(TXNRX_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_SETTLE =
        CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LD_FLUSH  =
        CW'(FLUSH_CYCLES - 1);

    logic [2:0]    state_d, state_q;
    logic [1:0]    target_d, target_q;
    logic          enable_d, enable_q;
    logic          txnrx_d, txnrx_q;
    logic          rx_en_d, rx_en_q;
    logic          tx_en_d, tx_en_q;
    logic          ready_d, ready_q;
    logic [1:0]    cur_mode_d, cur_mode_q;
    logic          accept;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;

    ad9364_ensm_ctrl_timer #(
        .W(CW)
    ) u_timer (
        .clk     (clk),
        .reset_b (reset_b),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    // ready_q is only ever high in ALERT/ACTIVE, so it gates acceptance
    assign accept = cmd_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_ALERT: begin
                if (accept && cmd_mode != MODE_ALERT) begin
                    target_d = cmd_mode;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_RAMP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETTLE;
                end
            end
            ST_RAMP: begin
                if (tmr_done) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (accept && cmd_mode != target_q) begin
                    target_d = cmd_mode;
                    state_d  = ST_FLUSH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (tmr_done) begin
                    state_d  = ST_DROP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETTLE;
                end
            end
            ST_DROP: begin
                if (tmr_done) begin
                    if (target_q == MODE_ALERT) begin
                        state_d = ST_ALERT;
                    end else begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SETUP;
                    end
                end
            end
            default: begin
                state_d  = ST_ALERT;
                target_d = MODE_ALERT;
            end
        endcase
    end

    // Outputs decode the current state one cycle late; TXNRX only
    // follows the target from SETUP onward, which ENABLE low guards.
    always_comb begin
        enable_d = (state_q == ST_RAMP)   ||
                   (state_q == ST_ACTIVE) ||
                   (state_q == ST_FLUSH);
        txnrx_d  = txnrx_q;
        if ((state_q == ST_SETUP) ||
            (state_q == ST_RAMP)  ||
            (state_q == ST_ACTIVE)) begin
            txnrx_d = (target_q != MODE_RX);
        end
        rx_en_d  = (state_q == ST_ACTIVE) && target_q[0];
        tx_en_d  = (state_q == ST_ACTIVE) && target_q[1];
        // drop ready in the same edge that starts a new sequence
        ready_d  = ((state_q == ST_ALERT) ||
                    (state_q == ST_ACTIVE)) &&
                   (state_d == state_q);
        cur_mode_d = MODE_ALERT;
        if ((state_q == ST_ACTIVE) && ready_d) begin
            cur_mode_d = target_q;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_ALERT;
            target_q   <= MODE_ALERT;
            enable_q   <= 1'b0;
            txnrx_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            tx_en_q    <= 1'b0;
            ready_q    <= 1'b1;
            cur_mode_q <= MODE_ALERT;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            enable_q   <= enable_d;
            txnrx_q    <= txnrx_d;
            rx_en_q    <= rx_en_d;
            tx_en_q    <= tx_en_d;
            ready_q    <= ready_d;
            cur_mode_q <= cur_mode_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = ~ready_q;
    assign xcvr_enable = enable_q;
    assign xcvr_txnrx  = txnrx_q;
    assign rx_enable   = rx_en_q;
    assign tx_enable   = tx_en_q;
    assign cur_mode    = cur_mode_q;

endmodule
